// File: rtl/detect_pkg.sv
// Shared types and constants for the detect scheduler and its pattern detector.
package detect_pkg;

   // Scheduler FSM states: wait for work, stream job bits, drain detector, report.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Default sequence to detect, oldest bit in the MSB.
   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

   // Round-robin pick between two requesters: a lone request wins outright,
   // a tie goes to whoever was not served last. Returns the winner index.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11) begin
         return ~last;
      end
      return req[1];
   endfunction

endpackage

// File: rtl/pattern_detect.sv
// Serial detector for a 4-bit pattern with overlapping matches. The output is
// a Moore output: it reflects the history after the last accepted bit.
module pattern_detect
   import detect_pkg::*;
#(
   parameter logic [3:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic q
);

   logic [3:0] hist_q;
   logic [2:0] fill_q;

   // Shift history left (newest bit in LSB) and count fill up to four bits.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= 4'b0000;
         fill_q <= 3'd0;
      end else if (clr) begin
         hist_q <= 4'b0000;
         fill_q <= 3'd0;
      end else if (en) begin
         hist_q <= {hist_q[2:0], din};
         if (fill_q != 3'd4) begin
            fill_q <= fill_q + 3'd1;
         end
      end
   end

   // A match needs four real bits in the history, so stale zeros never match.
   assign q = (fill_q == 3'd4) && (hist_q == PATTERN);

endmodule

// File: rtl/detect_scheduler.sv
// Two-requester round-robin job scheduler. Each granted job word is streamed
// MSB first through a pattern detector; matches are counted (saturating) and
// reported with a one-cycle done pulse.
module detect_scheduler
   import detect_pkg::*;
#(
   parameter int         WORD_W  = 8,
   parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
   parameter int         CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [WORD_W-1:0] data0,
   input  logic [WORD_W-1:0] data1,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              done,
   output logic              done_id,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              hit
);

   localparam int               BC_W     = $clog2(WORD_W);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic [WORD_W-1:0]   shreg_q, shreg_d;
   logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
   logic                done_id_q, done_id_d;

   logic                winner;
   logic [CNT_W-1:0]    cnt_inc;
   logic                det_clr;
   logic                det_en;
   logic                det_q;

   pattern_detect #(
      .PATTERN (PATTERN)
   ) u_detect (
      .clk (clk),
      .rst (rst),
      .clr (det_clr),
      .en  (det_en),
      .din (shreg_q[WORD_W-1]),
      .q   (det_q)
   );

   // Next-state logic: arbitration, bit streaming, match counting, reporting.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      match_cnt_d = match_cnt_q;
      done_id_d   = done_id_q;
      det_clr     = 1'b0;
      det_en      = 1'b0;
      winner      = rr_pick(req, last_q);

      cnt_inc = cnt_q;
      if (det_q && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               state_d   = SHIFT;
               grant_d   = winner ? 2'b10 : 2'b01;
               shreg_d   = winner ? data1 : data0;
               last_d    = winner;
               bit_cnt_d = '0;
               cnt_d     = '0;
               det_clr   = 1'b1;
            end
         end
         SHIFT: begin
            det_en    = 1'b1;
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
            // The first SHIFT cycle sees history from before any job bit.
            if (bit_cnt_q != '0) begin
               cnt_d = cnt_inc;
            end
            if (bit_cnt_q == LAST_BIT) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // Last sample covers the final job bit; publish the result now.
            cnt_d       = cnt_inc;
            match_cnt_d = cnt_inc;
            done_id_d   = grant_q[1];
            state_d     = DONE;
         end
         DONE: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         match_cnt_q <= '0;
         done_id_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         match_cnt_q <= match_cnt_d;
         done_id_q   <= done_id_d;
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign done_id   = done_id_q;
   assign match_cnt = match_cnt_q;
   assign hit       = (match_cnt_q != '0);

endmodule
